busy_dispatch: RTL and testbench

- Initiator side of the start/busy handshake. It queues upstream job requests and issues one-cycle start pulses to a busy-style resource (start in, busy out) only while that resource is idle.
- It tracks each job through to the falling edge of busy, counts completions, and flags protocol faults: no busy response to a start, or busy held too long.
- It sits between a job producer using a valid/ready interface and a single busy-counter resource.

---
 rtl/busy_dispatch.sv | 109 ++++++++++
 tb/tb_busy_dispatch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/busy_dispatch.sv
// Start/busy initiator: queues job requests and starts a busy-style resource only while it is
// idle, then follows each job to the falling edge of busy and flags protocol faults.
module busy_dispatch #(
    parameter int unsigned MAX_PENDING = 7,
    parameter int unsigned TIMEOUT     = 32,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    output logic             o_start,
    input  logic             i_busy,
    output logic             o_done,
    output logic [7:0]       o_pending,
    output logic [CNT_W-1:0] o_completed,
    output logic             o_err_noresp,
    output logic             o_err_timeout
);

    localparam logic [7:0]  MaxPend = 8'(MAX_PENDING);
    localparam logic [15:0] WdLast  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StRun} state_t;

    state_t      state;
    logic [7:0]  pending;
    logic [15:0] watchdog;
    logic        first_run;
    logic        accept;
    logic        issue;

    assign o_req_ready = (pending != MaxPend);
    assign o_pending   = pending;
    assign accept      = i_req_valid && o_req_ready;

    // A completing job may hand straight over to the next one: busy is already low.
    always_comb begin
        issue = 1'b0;
        unique case (state)
            StIdle:  issue = (pending != 8'd0) && !i_busy;
            StRun:   issue = !first_run && !i_busy && (pending != 8'd0);
            default: issue = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= StIdle;
            pending       <= 8'd0;
            watchdog      <= 16'd0;
            first_run     <= 1'b0;
            o_start       <= 1'b0;
            o_done        <= 1'b0;
            o_completed   <= '0;
            o_err_noresp  <= 1'b0;
            o_err_timeout <= 1'b0;
        end else begin
            unique case ({accept, issue})
                2'b10:   pending <= pending + 8'd1;
                2'b01:   pending <= pending - 8'd1;
                default: pending <= pending;
            endcase

            o_start <= 1'b0;
            o_done  <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (issue) begin
                        state   <= StIssue;
                        o_start <= 1'b1;
                    end
                end
                StIssue: begin
                    state     <= StRun;
                    watchdog  <= 16'd0;
                    first_run <= 1'b1;
                end
                StRun: begin
                    first_run <= 1'b0;
                    if (!i_busy) begin
                        if (first_run) begin
                            o_err_noresp <= 1'b1;
                            state        <= StIdle;
                        end else begin
                            o_done      <= 1'b1;
                            o_completed <= o_completed + CNT_W'(1);
                            if (issue) begin
                                state   <= StIssue;
                                o_start <= 1'b1;
                            end else begin
                                state <= StIdle;
                            end
                        end
                    end else if (watchdog == WdLast) begin
                        // Abort; IDLE will hold off until the resource drops busy.
                        o_err_timeout <= 1'b1;
                        state         <= StIdle;
                    end else begin
                        watchdog <= watchdog + 16'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_busy_dispatch.sv
// Randomized bench for busy_dispatch: a job-level reference model with a simple busy resource.
module tb_busy_dispatch;

    localparam int MAX_PENDING = 7;
    localparam int TIMEOUT     = 32;
    localparam int CNT_W       = 4;

    logic             i_clk;
    logic             i_reset;
    logic             i_req_valid;
    logic             o_req_ready;
    logic             o_start;
    logic             i_busy;
    logic             o_done;
    logic [7:0]       o_pending;
    logic [CNT_W-1:0] o_completed;
    logic             o_err_noresp;
    logic             o_err_timeout;

    busy_dispatch #(
        .MAX_PENDING(MAX_PENDING),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .o_start      (o_start),
        .i_busy       (i_busy),
        .o_done       (o_done),
        .o_pending    (o_pending),
        .o_completed  (o_completed),
        .o_err_noresp (o_err_noresp),
        .o_err_timeout(o_err_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: a job is either absent or was started at cycle m_ts.
    int m_pend = 0;
    int m_comp = 0;
    bit m_start = 0, m_done = 0, m_enr = 0, m_eto = 0;
    bit m_job = 0;
    int m_ts = 0;

    // Resource: raises busy for res_len cycles starting the cycle after a start.
    int res_cnt = 0;
    int res_len = 21;
    bit force_low = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit valid, input bit rst);
        bit busy, acc, iss;
        int k;
        busy = force_low ? 1'b0 : (res_cnt > 0);
        if (res_cnt > 0) res_cnt--;
        if (m_start && !force_low) res_cnt = res_len;
        i_req_valid = valid;
        i_busy      = busy;
        i_reset     = rst;
        #1;
        if (!rst) check("req_ready", 32'(o_req_ready), 32'(m_pend != MAX_PENDING));

        if (rst) begin
            m_pend = 0; m_comp = 0; m_start = 0; m_done = 0;
            m_enr = 0; m_eto = 0; m_job = 0;
        end else begin
            acc = valid && (m_pend != MAX_PENDING);
            iss = 1'b0;
            m_start = 1'b0;
            m_done  = 1'b0;
            if (!m_job) begin
                iss = (m_pend != 0) && !busy;
            end else if (cyc > m_ts) begin
                k = cyc - m_ts - 1;
                if (!busy) begin
                    m_job = 1'b0;
                    if (k == 0) begin
                        m_enr = 1'b1;
                    end else begin
                        m_done = 1'b1;
                        m_comp = (m_comp + 1) % (1 << CNT_W);
                        iss    = (m_pend != 0);
                    end
                end else if (k == TIMEOUT - 1) begin
                    m_eto = 1'b1;
                    m_job = 1'b0;
                end
            end
            if (iss) begin
                m_start = 1'b1;
                m_job   = 1'b1;
                m_ts    = cyc + 1;
            end
            m_pend = m_pend + int'(acc) - int'(iss);
        end

        @(posedge i_clk);
        #1;
        cyc++;
        check("start",       32'(o_start),       32'(m_start));
        check("done",        32'(o_done),        32'(m_done));
        check("pending",     32'(o_pending),     32'(m_pend));
        check("completed",   32'(o_completed),   32'(m_comp));
        check("err_noresp",  32'(o_err_noresp),  32'(m_enr));
        check("err_timeout", 32'(o_err_timeout), 32'(m_eto));
    endtask

    task automatic run(input int n, input bit valid);
        for (int i = 0; i < n; i++) step(valid, 1'b0);
    endtask

    initial begin
        i_reset     = 1'b1;
        i_req_valid = 1'b0;
        i_busy      = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Single job with a 21-cycle busy response.
        res_len = 21;
        step(1'b1, 1'b0);
        run(30, 1'b0);
        check("single_completed", 32'(o_completed), 32'd1);
        check("single_pending",   32'(o_pending),   32'd0);

        // Burst into the queue, then drain.
        res_len = 5;
        run(10, 1'b1);
        run(120, 1'b0);

        // Handover: second request lands while the first issues.
        res_len = 8;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        run(30, 1'b0);

        // Resource never answers.
        force_low = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        run(20, 1'b0);
        check("noresp_flag", 32'(o_err_noresp), 32'd1);
        force_low = 1'b0;

        // Busy stuck high, then released.
        res_len = 1000;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        run(60, 1'b0);
        check("timeout_flag", 32'(o_err_timeout), 32'd1);
        res_cnt = 0;
        res_len = 6;
        run(40, 1'b0);

        // Reset in the middle of a busy period with a queue behind it.
        res_len = 30;
        run(4, 1'b1);
        run(12, 1'b0);
        step(1'b0, 1'b1);
        check("rst_pending",   32'(o_pending),     32'd0);
        check("rst_completed", 32'(o_completed),   32'd0);
        check("rst_start",     32'(o_start),       32'd0);
        check("rst_errs",      32'({o_err_noresp, o_err_timeout}), 32'd0);
        run(40, 1'b0);

        // Randomized traffic with occasional no-response, timeout and reset.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0)      res_len = 0;
            else if (r == 1) res_len = 40;
            else             res_len = int'($urandom_range(1, 12));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
